// File: rtl/key_stream_loader_if.sv
// Byte handshake between a key source and key_stream_loader.
// In-band parity bit present only when KEY_PARITY_CHECK_EN is defined.
interface key_stream_loader_if #(
  parameter int unsigned BYTE_W = 8
);
  logic [BYTE_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
`ifdef KEY_PARITY_CHECK_EN
  logic              in_parity;

  modport master (output in_data, output in_valid, output in_parity, input in_ready);
  modport slave  (input in_data, input in_valid, input in_parity, output in_ready);
`else
  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
`endif
endinterface

// File: rtl/key_stream_loader.sv
// Feeds the SIPO key shift register: accepts key bytes and serialises them MSB-first.
// Optional odd-parity checking on incoming bytes is enabled by defining KEY_PARITY_CHECK_EN.
module key_stream_loader #(
  parameter int unsigned SIZE   = 256,
  parameter int unsigned BYTE_W = 8,
  parameter int unsigned CNT_W  = 9
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  key_stream_loader_if.slave   in_bus,
  output logic                 shift,
  output logic                 s_out,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     bit_count
`ifdef KEY_PARITY_CHECK_EN
  ,
  output logic                 parity_err
`endif
);

  localparam int unsigned NBYTES = SIZE / BYTE_W;
  localparam int unsigned IDX_W  = (BYTE_W > 1) ? $clog2(BYTE_W) : 1;
  localparam int unsigned BCNT_W = $clog2(NBYTES + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [BYTE_W-1:0] byte_buf;
  logic [IDX_W-1:0]  bit_idx;
  logic [BCNT_W-1:0] byte_cnt;
  logic              accept;
  logic              last_bit;
  logic              byte_ok;
  logic              start_ok;

`ifdef KEY_PARITY_CHECK_EN
  // Odd parity over data plus parity bit.
  assign byte_ok = ^{in_bus.in_data, in_bus.in_parity};
`else
  assign byte_ok = 1'b1;
`endif

  assign start_ok = (state == S_IDLE) && start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode and per-cycle strobes.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last_bit  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (in_bus.in_valid) begin
          accept    = 1'b1;
          state_nxt = byte_ok ? S_SHIFT : S_IDLE;
        end
      end
      S_SHIFT: begin
        if (bit_idx == IDX_W'(BYTE_W - 1)) begin
          last_bit  = 1'b1;
          state_nxt = (byte_cnt == BCNT_W'(NBYTES - 1)) ? S_DONE : S_LOAD;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Byte buffer, bit/byte counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_buf  <= '0;
      bit_idx   <= '0;
      byte_cnt  <= '0;
      bit_count <= '0;
    end else begin
      if (start_ok) begin
        byte_cnt  <= '0;
        bit_count <= '0;
      end
      if (accept) begin
        byte_buf <= in_bus.in_data;
        bit_idx  <= '0;
      end
      if (state == S_SHIFT) begin
        byte_buf  <= byte_buf << 1;
        bit_idx   <= bit_idx + IDX_W'(1);
        bit_count <= bit_count + CNT_W'(1);
        if (last_bit) byte_cnt <= byte_cnt + BCNT_W'(1);
      end
    end
  end

`ifdef KEY_PARITY_CHECK_EN
  // Sticky until the next accepted start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    parity_err <= 1'b0;
    else if (start_ok)            parity_err <= 1'b0;
    else if (accept && !byte_ok)  parity_err <= 1'b1;
  end
`endif

  assign in_bus.in_ready = (state == S_LOAD);
  assign shift           = (state == S_SHIFT);
  assign busy            = (state != S_IDLE);
  assign done            = (state == S_DONE);
  assign s_out           = byte_buf[BYTE_W-1];

endmodule

// File: tb/tb_key_stream_loader.sv
// Directed bench for key_stream_loader with a behavioural SIPO on the serial side.
// Parity scenarios run only when KEY_PARITY_CHECK_EN is defined.
module tb_key_stream_loader;

  localparam int unsigned SIZE   = 256;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 9;
  localparam int unsigned NBYTES = SIZE / BYTE_W;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             shift;
  logic             s_out;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] bit_count;
`ifdef KEY_PARITY_CHECK_EN
  logic             parity_err;
`endif

  key_stream_loader_if #(.BYTE_W(BYTE_W)) bus ();

  key_stream_loader #(.SIZE(SIZE), .BYTE_W(BYTE_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_bus    (bus),
    .shift     (shift),
    .s_out     (s_out),
    .busy      (busy),
    .done      (done),
    .bit_count (bit_count)
`ifdef KEY_PARITY_CHECK_EN
    ,
    .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural downstream SIPO, reset together with the loader.
  logic [SIZE-1:0] p_out;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      p_out <= '0;
    else if (shift) p_out <= {p_out[SIZE-2:0], s_out};
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [SIZE-1:0] got, input logic [SIZE-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Results of the most recent run_load.
  int done_cyc, done_cnt, first_shift, last_shift, shift_cnt, overlap, mono_err, end_cyc;
  bit timed_out;

  task automatic run_load(input bit gaps, input bit poke, input int bad_idx);
    int idx, gap, cyc;
    logic took;
    logic [CNT_W-1:0] prev_bc;
    logic [7:0] b;
    done_cyc = -1; done_cnt = 0; first_shift = -1; last_shift = -1;
    shift_cnt = 0; overlap = 0; mono_err = 0; timed_out = 0;
    idx = 0; gap = 0;
    start = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 8'($urandom);
    tick();
    cyc = 1;
    start = 1'b0;
    prev_bc = bit_count;
    while (busy) begin
      if (cyc > 600) begin
        timed_out = 1'b1;
        break;
      end
      if (shift) begin
        if (first_shift < 0) first_shift = cyc;
        last_shift = cyc;
        shift_cnt++;
      end
      if (shift && bus.in_ready) overlap++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (bit_count < prev_bc) mono_err++;
      prev_bc = bit_count;
      start = poke && (shift || done);
      bus.in_valid = 1'b1;
      if (bus.in_ready) begin
        if (gaps && (idx % 4 == 3) && gap < 3) begin
          bus.in_valid = 1'b0;
          gap++;
        end
        b = 8'(idx);
        bus.in_data = b;
`ifdef KEY_PARITY_CHECK_EN
        bus.in_parity = (~^b) ^ (idx == bad_idx);
`endif
      end else begin
        bus.in_data = 8'($urandom);
      end
      took = bus.in_ready && bus.in_valid;
      tick();
      cyc++;
      if (took) begin
        idx++;
        gap = 0;
      end
    end
    start = 1'b0;
    bus.in_valid = 1'b0;
    end_cyc = cyc;
  endtask

  logic [SIZE-1:0] exp_key;
  logic [7:0]      pat;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < int'(NBYTES); i++) exp_key[SIZE-1-8*i -: 8] = 8'(i);

    reset = 1'b1; start = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
`ifdef KEY_PARITY_CHECK_EN
    bus.in_parity = 1'b1;
`endif
    tick(); tick();
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_shift", shift, 0);
    check("rst_s_out", s_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_bit_count", bit_count, 0);
`ifdef KEY_PARITY_CHECK_EN
    check("rst_parity_err", parity_err, 0);
`endif
    reset = 1'b0;
    bus.in_valid = 1'b1;
    tick(); tick();
    check("idle_ignores_valid", bus.in_ready, 0);
    check("idle_bit_count", bit_count, 0);

    // Full key, back-to-back bytes.
    run_load(1'b0, 1'b0, -1);
    check("t1_timeout", timed_out, 0);
    check("t1_p_out", p_out, exp_key);
    check("t1_done_cyc", done_cyc, 289);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_first_shift", first_shift, 2);
    check("t1_last_shift", last_shift, 288);
    check("t1_shift_cnt", shift_cnt, 256);
    check("t1_idle_cyc", end_cyc, 290);
    check("t1_bit_count", bit_count, 256);
    tick(); tick(); tick();
    check("t1_bit_count_hold", bit_count, 256);

    // Three idle valid cycles before every 4th byte.
    run_load(1'b1, 1'b0, -1);
    check("t2_timeout", timed_out, 0);
    check("t2_p_out", p_out, exp_key);
    check("t2_done_cyc", done_cyc, 313);
    check("t2_last_shift", last_shift, 312);
    check("t2_shift_cnt", shift_cnt, 256);
    check("t2_shift_in_load", overlap, 0);

    // Start pokes during SHIFT and DONE.
    run_load(1'b0, 1'b1, -1);
    check("t3_timeout", timed_out, 0);
    check("t3_done_cnt", done_cnt, 1);
    check("t3_done_cyc", done_cyc, 289);
    check("t3_monotonic", mono_err, 0);
    check("t3_bit_count", bit_count, 256);
    check("t3_p_out", p_out, exp_key);
    tick();
    check("t3_no_restart", busy, 0);

    // Single byte 0xA5, bit-level.
    pat = 8'hA5;
    start = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'hA5;
`ifdef KEY_PARITY_CHECK_EN
    bus.in_parity = ~^pat;
`endif
    tick();
    start = 1'b0;
    check("t4_count_cleared", bit_count, 0);
    check("t4_in_ready", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    bus.in_data = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t4_shift%0d", i), shift, 1);
      check($sformatf("t4_bit%0d", i), s_out, pat[7-i]);
      tick();
    end
    check("t4_back_to_load", bus.in_ready, 1);
    check("t4_shift_low", shift, 0);
    check("t4_bit_count", bit_count, 8);
    tick(); tick(); tick();
    check("t4_wait_load", bus.in_ready, 1);
    check("t4_wait_count", bit_count, 8);
    check("t4_sipo_low", p_out[7:0], 8'hA5);
    reset = 1'b1; tick(); reset = 1'b0; tick();

    // Reset in the middle of byte 12.
    start = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'h5A;
`ifdef KEY_PARITY_CHECK_EN
    bus.in_parity = 1'b1;
`endif
    tick();
    start = 1'b0;
    for (int c = 0; c < 400 && bit_count != CNT_W'(100); c++) tick();
    check("t5_reached_100", bit_count, 100);
    check("t5_shift_before", shift, 1);
    reset = 1'b1;
    #1;
    check("t5_shift_async", shift, 0);
    check("t5_busy", busy, 0);
    check("t5_in_ready", bus.in_ready, 0);
    check("t5_done", done, 0);
    check("t5_s_out", s_out, 0);
    check("t5_bit_count", bit_count, 0);
    tick();
    reset = 1'b0;
    tick();
    run_load(1'b0, 1'b0, -1);
    check("t5_timeout", timed_out, 0);
    check("t5_p_out", p_out, exp_key);
    check("t5_done_cyc", done_cyc, 289);

`ifdef KEY_PARITY_CHECK_EN
    // Fifth byte with bad parity.
    run_load(1'b0, 1'b0, 4);
    check("t6_timeout", timed_out, 0);
    check("t6_parity_err", parity_err, 1);
    check("t6_idle", busy, 0);
    check("t6_bit_count", bit_count, 32);
    check("t6_no_done", done_cnt, 0);
    check("t6_shift_cnt", shift_cnt, 32);
    tick(); tick();
    check("t6_sticky", parity_err, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t6_cleared", parity_err, 0);
    check("t6_restart", bus.in_ready, 1);
    reset = 1'b1; tick(); reset = 1'b0; tick();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
